// File: rtl/video_fill_engine.sv
// Rectangle-fill bus master: latches a rectangle, clips it to the screen and
// streams word-aligned, byte-enabled writes of a fill colour into one of two frames.
module video_fill_engine #(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 240,
  parameter logic [31:0] FRAME0_BASE   = 32'hFF00_0000,
  parameter logic [31:0] FRAME1_BASE   = 32'hFF10_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [8:0]  rect_x,
  input  logic [7:0]  rect_y,
  input  logic [8:0]  rect_width,
  input  logic [7:0]  rect_height,
  input  logic [7:0]  rect_color,
  input  logic        rect_frame,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_write_enable,
  output logic        bus_read_enable,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam logic [9:0] W_LIM = 10'(SCREEN_WIDTH);
  localparam logic [8:0] H_LIM = 9'(SCREEN_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIP,
    S_ROW,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [8:0]  r_x;
  logic [7:0]  r_y;
  logic [8:0]  r_w;
  logic [7:0]  r_h;
  logic [7:0]  r_color;
  logic        r_frame;
  logic [9:0]  r_x_end;
  logic [8:0]  r_y_end;
  logic [7:0]  r_row;
  logic [31:0] r_row_start;
  logic [31:0] r_row_stop;
  logic [31:0] r_ptr;
  logic        r_abort_pend;
  logic        r_aborted;

  logic [9:0]  w_x_sum;
  logic [8:0]  w_y_sum;
  logic [9:0]  w_x_end;
  logic [8:0]  w_y_end;
  logic        w_empty;
  logic [31:0] w_row_base;
  logic [31:0] w_row_start;
  logic [31:0] w_row_stop;
  logic [3:0]  w_be;
  logic        w_last_word;
  logic        w_last_row;
  logic        w_set_aborted;

  // Clipping: sums are one bit wider than the operands so they cannot wrap.
  assign w_x_sum = {1'b0, r_x} + {1'b0, r_w};
  assign w_y_sum = {1'b0, r_y} + {1'b0, r_h};
  assign w_x_end = (w_x_sum > W_LIM) ? W_LIM : w_x_sum;
  assign w_y_end = (w_y_sum > H_LIM) ? H_LIM : w_y_sum;
  assign w_empty = (r_w == '0) || (r_h == '0) ||
                   ({1'b0, r_x} >= W_LIM) || ({1'b0, r_y} >= H_LIM);

  assign w_row_base  = (r_frame ? FRAME1_BASE : FRAME0_BASE) + 32'(r_row) * SCREEN_WIDTH;
  assign w_row_start = w_row_base + 32'(r_x);
  assign w_row_stop  = w_row_base + 32'(r_x_end);

  assign w_last_word = (r_ptr + 32'd4) >= r_row_stop;
  assign w_last_row  = ({1'b0, r_row} + 9'd1) == r_y_end;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_be = '0;
    for (int k = 0; k < 4; k++) begin
      w_be[k] = ((r_ptr + 32'(k)) >= r_row_start) && ((r_ptr + 32'(k)) < r_row_stop);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_set_aborted = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_CLIP;
      end
      S_CLIP: begin
        if (abort) begin
          w_state_next  = S_DONE;
          w_set_aborted = 1'b1;
        end else if (w_empty) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_ROW;
        end
      end
      S_ROW: begin
        if (abort) begin
          w_state_next  = S_DONE;
          w_set_aborted = 1'b1;
        end else begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        // Completing the final word wins over an abort: the fill did finish.
        if (bus_ready) begin
          if (w_last_word && w_last_row) begin
            w_state_next = S_DONE;
          end else if (abort || r_abort_pend) begin
            w_state_next  = S_DONE;
            w_set_aborted = 1'b1;
          end else if (w_last_word) begin
            w_state_next = S_ROW;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_aborted <= w_set_aborted;
      if (r_state == S_WRITE) begin
        if (abort) r_abort_pend <= 1'b1;
      end else begin
        r_abort_pend <= 1'b0;
      end
    end
  end

  // NOTE: datapath registers are reset too, so a dropped fill leaves no stale pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_color     <= '0;
      r_frame     <= 1'b0;
      r_x_end     <= '0;
      r_y_end     <= '0;
      r_row       <= '0;
      r_row_start <= '0;
      r_row_stop  <= '0;
      r_ptr       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= rect_x;
            r_y     <= rect_y;
            r_w     <= rect_width;
            r_h     <= rect_height;
            r_color <= rect_color;
            r_frame <= rect_frame;
          end
        end
        S_CLIP: begin
          r_x_end <= w_x_end;
          r_y_end <= w_y_end;
          r_row   <= r_y;
        end
        S_ROW: begin
          r_row_start <= w_row_start;
          r_row_stop  <= w_row_stop;
          r_ptr       <= {w_row_start[31:2], 2'b00};
        end
        S_WRITE: begin
          if (bus_ready) begin
            if (w_last_word) r_row <= r_row + 8'd1;
            else             r_ptr <= r_ptr + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_write_enable = (r_state == S_WRITE);
  assign bus_address      = bus_write_enable ? r_ptr : '0;
  assign bus_write_data   = bus_write_enable ? {4{r_color}} : '0;
  assign bus_byte_enable  = bus_write_enable ? w_be : '0;
  assign bus_read_enable  = 1'b0;
  assign busy             = (r_state == S_CLIP) || (r_state == S_ROW) || (r_state == S_WRITE);
  assign done             = (r_state == S_DONE);
  assign aborted          = done && r_aborted;

endmodule

// File: doc/video_fill_engine.md
Name: video_fill_engine

Overview:
- Hardware rectangle-fill accelerator upstream of the video framebuffer bus port.
- Latches a rectangle (x, y, width, height, 8-bit colour, frame select) on a start pulse, clips it to the screen, and streams word-aligned, byte-enabled writes into frame 0 or frame 1.
- Frees the core from per-pixel store loops.
- Its bus master outputs feed the framebuffer bus inputs (bus_address, bus_write_data, bus_byte_enable, bus_write_enable, bus_read_enable) through the bus arbiter.

Parameters:
- SCREEN_WIDTH, 320, pixels per line (bytes per row, 8 bpp).
- SCREEN_HEIGHT, 240, lines per frame.
- FRAME0_BASE, 32'hFF00_0000, byte address of frame 0.
- FRAME1_BASE, 32'hFF10_0000, byte address of frame 1.

Ports:
- clock  in  1  single block clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  stop the fill early.
- rect_x  in  9  left column.
- rect_y  in  8  top row.
- rect_width  in  9  pixels per row.
- rect_height  in  8  rows.
- rect_color  in  8  fill byte.
- rect_frame  in  1  0 = frame 0, 1 = frame 1.
- bus_ready  in  1  write accepted on this rising edge.
- bus_address  out  32  word-aligned byte address ([1:0] = 0).
- bus_write_data  out  32  rect_color replicated ×4.
- bus_byte_enable  out  4  lane k = byte at address+k (little-endian, bits 8k+7:8k).
- bus_write_enable  out  1  write request.
- bus_read_enable  out  1  tied 0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; 1 if ended by abort.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs 0; counters cleared. An outstanding write is dropped with no further assertion.
- FSM states:
  - IDLE: start=1 latches all rect_* inputs and goes to CLIP. start while not IDLE is ignored.
  - CLIP (1 cycle): x_end = min(rect_x + rect_width, SCREEN_WIDTH), 10-bit sum; y_end = min(rect_y + rect_height, SCREEN_HEIGHT), 9-bit sum. If rect_width==0, rect_height==0, rect_x>=SCREEN_WIDTH or rect_y>=SCREEN_HEIGHT, go to DONE with zero writes; else go to ROW.
  - ROW (1 cycle): row_start = base + row*SCREEN_WIDTH + rect_x; row_stop = base + row*SCREEN_WIDTH + x_end. Word pointer = row_start & ~3. Go to WRITE.
  - WRITE: bus_write_enable=1. Address, data and byte_enable are held stable until bus_ready=1. byte_enable[k] = 1 iff (pointer+k) is within [row_start, row_stop). On bus_ready: if pointer+4 >= row_stop, advance the row (row+1 == y_end → DONE, else → ROW); otherwise pointer += 4 and stay in WRITE.
  - DONE (1 cycle): done=1, busy=0, then back to IDLE.
- Throughput: one word per cycle while bus_ready=1, plus one ROW bubble per row. Latency: start at edge N → bus_write_enable first high at N+3 (CLIP, ROW in between).
- bus_write_enable drops in the cycle after the final acceptance. It is never asserted with byte_enable == 0.
- Abort:
  - In CLIP or ROW: go to DONE with aborted=1.
  - In WRITE: the current write still completes (waits for bus_ready), then DONE with aborted=1.
  - In IDLE: ignored.
- Simultaneous abort and final bus_ready: DONE with aborted=0.
- Row multiply: constant SCREEN_WIDTH × 8-bit row. Address arithmetic is 32-bit with no wrap inside a frame.

Test Plan:
- Basic word: x=0, y=0, w=4, h=1, color=A5, frame0, bus_ready=1 → one write: addr FF000000, data A5A5A5A5, be 1111. First write 3 cycles after start; done pulses one cycle after acceptance.
- Unaligned span: x=5, y=2, w=6, h=1 → writes FF000284 be 1110, then FF000288 be 0111; no other writes.
- Clipping, frame1: x=318, y=239, w=10, h=5 → exactly one write, FF112BFC be 1100; done with aborted=0.
- Back-pressure: case 2 with bus_ready low for 3 cycles on the first word → address, data and be held unchanged for 4 cycles; second word only after acceptance.
- Degenerate and ignored start: w=0 → done 2 cycles after start, zero writes. start pulsed while busy → no effect on the running fill.
- Abort and reset: 4×3 fill, abort raised in WRITE with bus_ready low → request held until bus_ready, then done=1, aborted=1. Separately, reset=0 mid-fill → all outputs 0 immediately, IDLE.
